// File: rtl/util_control_pkg.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : util_control_pkg
// Brief    : Shared clock/reset bundle type and helpers for pipeline utilities.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package util_control_pkg;

    typedef struct packed {
        logic clock;
        logic reset_n;
    } ctrl_t;

    // Level that reset_n takes while reset is asserted.
    localparam logic c_reset_active = 1'b0;

    function automatic ctrl_t pack_ctrl(input logic clock, input logic reset_n);
        ctrl_t r;
        r.clock   = clock;
        r.reset_n = reset_n;
        return r;
    endfunction

    function automatic logic ctrl_in_reset(input ctrl_t ctrl);
        return (ctrl.reset_n == c_reset_active);
    endfunction

endpackage

`define UTIL_CTRL_CLOCK(ctrl)   ((ctrl).clock)
`define UTIL_CTRL_RESET_N(ctrl) ((ctrl).reset_n)

`default_nettype wire

// File: rtl/delay_array_stage.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : delay_stage
// Brief    : One WIDTH-bit register with asynchronous active-low clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module delay_stage
    import util_control_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (reset_n == c_reset_active) begin
            r_q <= '0;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/delay_array.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : delay_array
// Brief    : Fixed-latency register chain delaying a WIDTH-bit word by DELAY clocks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module delay_array
    import util_control_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    generate
        if (DELAY == 0) begin : g_passthru
            // No storage exists, so clock and reset are intentionally ignored.
            logic w_unused_ctrl;
            assign w_unused_ctrl = &{1'b0, clock, reset_n};
            assign out = in;
        end else begin : g_pipe
            logic [WIDTH-1:0] w_stage [DELAY];

            for (genvar k = 0; k < DELAY; k++) begin : g_stage
                logic [WIDTH-1:0] w_d;

                if (k == 0) begin : g_head
                    assign w_d = in;
                end else begin : g_link
                    assign w_d = w_stage[k-1];
                end

                delay_stage #(
                    .WIDTH (WIDTH)
                ) u_stage (
                    .clock   (clock),
                    .reset_n (reset_n),
                    .d       (w_d),
                    .q       (w_stage[k])
                );
            end

            assign out = w_stage[DELAY-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_delay_array.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_delay_array
// Brief    : Self-checking bench for delay_array at DELAY = 2, 0 and 5.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_delay_array;

    localparam int c_delay_a = 2;
    localparam int c_delay_c = 5;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       reset_b;
    logic [3:0] in_a, out_a;
    logic [3:0] in_b, out_b;
    logic [7:0] in_c, out_c;

    int checks   = 0;
    int errors   = 0;
    int ff_count = 0;

    logic [3:0] q_a [$];
    logic [7:0] q_c [$];

    typedef struct packed {
        logic [3:0] din;
        logic       rst_n;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [6];

    always #1 clock = ~clock;

    delay_array #(.WIDTH(4), .DELAY(c_delay_a)) u_dut_a (
        .clock (clock), .reset_n (reset_n), .in (in_a), .out (out_a)
    );

    delay_array #(.WIDTH(4), .DELAY(0)) u_dut_b (
        .clock (clock), .reset_n (reset_b), .in (in_b), .out (out_b)
    );

    delay_array #(.WIDTH(8), .DELAY(c_delay_c)) u_dut_c (
        .clock (clock), .reset_n (reset_n), .in (in_c), .out (out_c)
    );

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // After reset the chain holds zeros; a word captured at an edge
    // is visible DELAY-1 edges later.
    task automatic prefill();
        q_a.delete();
        q_c.delete();
        for (int i = 0; i < c_delay_a - 1; i++) q_a.push_back(4'h0);
        for (int i = 0; i < c_delay_c - 1; i++) q_c.push_back(8'h00);
    endtask

    // Called just after a falling edge: drive, let one rising edge pass, check.
    task automatic tick(input logic [3:0] va, input logic [7:0] vc);
        in_a = va;
        in_c = vc;
        q_a.push_back(va);
        q_c.push_back(vc);
        @(posedge clock);
        @(negedge clock);
        check4("pipe_a", out_a, q_a.pop_front());
        check8("pipe_c", out_c, q_c.pop_front());
        if (out_c === 8'hFF) ff_count++;
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cnt;

        reset_n = 1'b0;
        reset_b = 1'b1;
        in_a    = 4'h0;
        in_b    = 4'h0;
        in_c    = 8'h00;

        tbl[0] = '{din: 4'hA, rst_n: 1'b1, exp: 4'hA};
        tbl[1] = '{din: 4'hA, rst_n: 1'b0, exp: 4'hA};
        tbl[2] = '{din: 4'hF, rst_n: 1'b0, exp: 4'hF};
        tbl[3] = '{din: 4'h0, rst_n: 1'b1, exp: 4'h0};
        tbl[4] = '{din: 4'h5, rst_n: 1'b1, exp: 4'h5};
        tbl[5] = '{din: 4'h3, rst_n: 1'b0, exp: 4'h3};

        // Zero-delay instance: pure wire, reset has no effect.
        for (int i = 0; i < 6; i++) begin
            in_b    = tbl[i].din;
            reset_b = tbl[i].rst_n;
            #0.1;
            check4("comb_b", out_b, tbl[i].exp);
        end

        // Reset held low for 4 units while the input keeps counting.
        check4("reset_a_t0", out_a, 4'h0);
        check8("reset_c_t0", out_c, 8'h00);
        repeat (2) begin
            @(negedge clock);
            check4("reset_a", out_a, 4'h0);
            check8("reset_c", out_c, 8'h00);
            in_a = in_a + 4'h1;
        end

        reset_n = 1'b1;
        prefill();
        cnt = in_a;
        for (int i = 0; i < 20; i++) begin
            tick(cnt, 8'h00);
            cnt = cnt + 4'h1;
        end

        // Asynchronous reset between edges must clear out before the next edge.
        @(posedge clock);
        #0.5;
        reset_n = 1'b0;
        #0.2;
        check4("async_a", out_a, 4'h0);
        check8("async_c", out_c, 8'h00);
        @(negedge clock);
        check4("async_hold_a", out_a, 4'h0);
        reset_n = 1'b1;
        prefill();

        // Single-cycle all-ones pulse through the 5-deep instance.
        tick(cnt, 8'hFF);
        cnt = cnt + 4'h1;
        for (int i = 0; i < 8; i++) begin
            tick(cnt, 8'h00);
            cnt = cnt + 4'h1;
        end

        checks++;
        if (ff_count != 1) begin
            errors++;
            $display("FAIL pulse_count actual=%0d required=1", ff_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
